// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// regfile_write_arbiter
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback sources. At most one request is granted per cycle; the
// granted request is registered into a write command for the register file.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   hold       blocks this cycle's grant
//   req_valid  per-requester valid
//   req_reg    per-requester destination index, requester i at [i*REG_BITS +: REG_BITS]
//   req_data   per-requester write data, requester i at [i*WORD_SIZE +: WORD_SIZE]
//   req_ready  combinational one-hot grant (or zero)
//   write_en   registered write enable to the register file
//   write_reg  registered destination index
//   write_data registered write data
//   grant_id   registered index of the requester whose write is on write_*
//   wr_count   count of accepted writes, wraps modulo 2^16
module regfile_write_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int REG_BITS  = 4,
  parameter int NUM_REQ   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_BITS-1:0]   req_reg,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          write_en,
  output logic [REG_BITS-1:0]           write_reg,
  output logic [WORD_SIZE-1:0]          write_data,
  output logic [2:0]                    grant_id,
  output logic [15:0]                   wr_count
);

  localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

  logic [2:0]           ptr;
  logic                 found;
  logic [2:0]           sel_id;
  logic [REG_BITS-1:0]  sel_reg;
  logic [WORD_SIZE-1:0] sel_data;
  int unsigned          scan_idx;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
  // Ready is only ever raised on a valid requester, so found == acceptance.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    sel_id    = '0;
    sel_reg   = '0;
    sel_data  = '0;
    scan_idx  = 0;
    if (rst_n && !hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = (32'(ptr) + k) % NUM_REQ;
        if (!found && req_valid[scan_idx]) begin
          found               = 1'b1;
          sel_id              = 3'(scan_idx);
          sel_reg             = req_reg[scan_idx*REG_BITS +: REG_BITS];
          sel_data            = req_data[scan_idx*WORD_SIZE +: WORD_SIZE];
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_id   <= '0;
      wr_count   <= '0;
    end else if (found) begin
      ptr        <= (sel_id == LAST_ID) ? '0 : sel_id + 3'd1;
      write_en   <= 1'b1;
      write_reg  <= sel_reg;
      write_data <= sel_data;
      grant_id   <= sel_id;
      wr_count   <= wr_count + 16'd1;
    end else begin
      write_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  localparam int W = 16;
  localparam int R = 4;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N*R-1:0] req_reg;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           write_en;
  logic [R-1:0]   write_reg;
  logic [W-1:0]   write_data;
  logic [2:0]     grant_id;
  logic [15:0]    wr_count;

  regfile_write_arbiter #(.WORD_SIZE(W), .REG_BITS(R), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .write_en(write_en), .write_reg(write_reg),
    .write_data(write_data), .grant_id(grant_id), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write command.
  logic [W-1:0] rf [16];
  always @(posedge clk) if (write_en) rf[write_reg] <= write_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] r0, input logic [15:0] d0,
                            input logic [3:0] r1, input logic [15:0] d1,
                            input logic [3:0] r2, input logic [15:0] d2);
    req_reg  = {r2, r1, r0};
    req_data = {d2, d1, d0};
  endtask

  task automatic default_fields();
    set_fields(4'd2, 16'hA0A0, 4'd5, 16'hBEEF, 4'd7, 16'hC3C3);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [2:0]  exp_gid;
    logic [3:0]  exp_reg;
    logic [15:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Applied from reset with default fields; ptr walks as annotated.
    vecs = '{
      '{1'b0, 3'b010, 3'b010, 1'b1, 3'd1, 4'd5, 16'hBEEF, 16'd1},  // ptr0 -> 2
      '{1'b0, 3'b000, 3'b000, 1'b0, 3'd1, 4'd5, 16'hBEEF, 16'd1},  // idle, fields hold
      '{1'b0, 3'b111, 3'b100, 1'b1, 3'd2, 4'd7, 16'hC3C3, 16'd2},  // ptr2 -> 0
      '{1'b0, 3'b111, 3'b001, 1'b1, 3'd0, 4'd2, 16'hA0A0, 16'd3},  // ptr0 -> 1
      '{1'b0, 3'b111, 3'b010, 1'b1, 3'd1, 4'd5, 16'hBEEF, 16'd4},  // ptr1 -> 2
      '{1'b0, 3'b011, 3'b001, 1'b1, 3'd0, 4'd2, 16'hA0A0, 16'd5},  // ptr2 wraps -> 1
      '{1'b1, 3'b111, 3'b000, 1'b0, 3'd0, 4'd2, 16'hA0A0, 16'd5},  // hold
      '{1'b0, 3'b101, 3'b100, 1'b1, 3'd2, 4'd7, 16'hC3C3, 16'd6},  // ptr1 -> 0
      '{1'b0, 3'b110, 3'b010, 1'b1, 3'd1, 4'd5, 16'hBEEF, 16'd7},  // ptr0 -> 2
      '{1'b0, 3'b001, 3'b001, 1'b1, 3'd0, 4'd2, 16'hA0A0, 16'd8}   // ptr2 -> 1
    };

    // Reset state, with requests already valid.
    rst_n = 1'b0; hold = 1'b0; req_valid = 3'b111; default_fields();
    #2;
    check("reset ready", 32'(req_ready), 0);
    check("reset write_en", 32'(write_en), 0);
    check("reset write_reg", 32'(write_reg), 0);
    check("reset write_data", 32'(write_data), 0);
    check("reset grant_id", 32'(grant_id), 0);
    check("reset wr_count", 32'(wr_count), 0);
    tick();
    req_valid = 3'b000;
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      hold = vecs[i].hold;
      req_valid = vecs[i].valid;
      #1;
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d write_en", i), 32'(write_en), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].exp_gid));
      check($sformatf("vec%0d write_reg", i), 32'(write_reg), 32'(vecs[i].exp_reg));
      check($sformatf("vec%0d write_data", i), 32'(write_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(vecs[i].exp_cnt));
    end
    hold = 1'b0; req_valid = 3'b000;

    // All three continuously valid for 6 cycles from reset.
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] e;
      e = 3'b001 << (k % 3);
      req_valid = 3'b111;
      #1;
      check($sformatf("rr%0d ready", k), 32'(req_ready), 32'(e));
      tick();
      check($sformatf("rr%0d write_en", k), 32'(write_en), 1);
      check($sformatf("rr%0d grant_id", k), 32'(grant_id), 32'(k % 3));
    end
    check("rr wr_count", 32'(wr_count), 6);
    req_valid = 3'b000;
    tick();
    check("rr idle write_en", 32'(write_en), 0);

    // Same-register conflict, serialized in grant order.
    apply_reset();
    set_fields(4'd3, 16'h1111, 4'd5, 16'hBEEF, 4'd3, 16'h2222);
    req_valid = 3'b101;
    #1;
    check("conf first ready", 32'(req_ready), 32'(3'b001));
    tick();
    req_valid = 3'b100;
    check("conf first data", 32'(write_data), 32'h1111);
    check("conf first reg", 32'(write_reg), 3);
    #1;
    check("conf second ready", 32'(req_ready), 32'(3'b100));
    tick();
    req_valid = 3'b000;
    check("conf second gid", 32'(grant_id), 2);
    check("conf second data", 32'(write_data), 32'h2222);
    tick();
    tick();
    check("conf rf[3] final", 32'(rf[3]), 32'h2222);
    default_fields();

    // Hold for 3 cycles with requester 0 valid.
    apply_reset();
    hold = 1'b1; req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold%0d ready", k), 32'(req_ready), 0);
      tick();
      check($sformatf("hold%0d write_en", k), 32'(write_en), 0);
      check($sformatf("hold%0d wr_count", k), 32'(wr_count), 0);
    end
    hold = 1'b0;
    #1;
    check("hold release ready", 32'(req_ready), 32'(3'b001));
    tick();
    check("hold release gid", 32'(grant_id), 0);
    check("hold release count", 32'(wr_count), 1);
    hold = 1'b1;
    #1;
    check("hold keeps staged write", 32'(write_en), 1);
    check("hold blocks ready", 32'(req_ready), 0);
    tick();
    check("hold no new write", 32'(write_en), 0);
    check("hold count frozen", 32'(wr_count), 1);
    hold = 1'b0; req_valid = 3'b000;

    // Reset pulse while requester 2's write is in the output stage.
    apply_reset();
    req_valid = 3'b100;
    #1;
    check("rst2 ready", 32'(req_ready), 32'(3'b100));
    tick();
    req_valid = 3'b011;
    check("rst2 staged write_en", 32'(write_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2 write_en drop", 32'(write_en), 0);
    check("rst2 wr_count", 32'(wr_count), 0);
    check("rst2 ready low", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst2 lowest first", 32'(req_ready), 32'(3'b001));
    // Grant 0 moves ptr to 1; a reset must bring it back to 0.
    tick();
    check("rst0 staged gid", 32'(grant_id), 0);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("rst0 ptr cleared", 32'(req_ready), 32'(3'b001));
    req_valid = 3'b000;

    // Counter wrap.
    apply_reset();
    req_valid = 3'b111;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap count max", 32'(wr_count), 32'hFFFF);
    tick();
    check("wrap count zero", 32'(wr_count), 0);
    req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
